// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: snoops CPU writes to the trigger register, halts the CPU
// and copies one 256-byte page to the OAM data port as alternating read/write cycles.
module nes_oam_dma #(
   parameter int                  NumDb    = 8,
   parameter logic [2*NumDb-1:0]  DMA_REG  = 16'h4014,
   parameter logic [2*NumDb-1:0]  OAM_PORT = 16'h2004
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic [2*NumDb-1:0]   cpu_addr,
   input  logic [NumDb-1:0]     cpu_data,
   input  logic                 cpu_r_bw,
   output logic                 cpu_rdy,
   output logic [2*NumDb-1:0]   bus_addr,
   output logic [NumDb-1:0]     bus_wdata,
   output logic                 bus_r_bw,
   input  logic [NumDb-1:0]     bus_rdata,
   output logic                 dma_active
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_parity;
   logic [NumDb-1:0]  r_page;
   logic [NumDb-1:0]  r_byte;
   logic [NumDb-1:0]  r_hold;
   logic              w_trigger;

   assign w_trigger = (cpu_r_bw == 1'b0) && (cpu_addr == DMA_REG);

   // HALT checks parity so that every READ lands on an even cycle; ALIGN pads one cycle otherwise.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state  <= IDLE;
         r_parity <= 1'b0;
         r_page   <= '0;
         r_byte   <= '0;
         r_hold   <= '0;
      end else begin
         r_parity <= ~r_parity;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_page  <= cpu_data;
                  r_byte  <= '0;
                  r_state <= HALT;
               end
            end
            HALT:  r_state <= r_parity ? READ : ALIGN;
            ALIGN: r_state <= READ;
            READ: begin
               r_hold  <= bus_rdata;
               r_state <= WRITE;
            end
            WRITE: begin
               if (r_byte == {NumDb{1'b1}}) begin
                  r_state <= IDLE;
               end else begin
                  r_byte  <= r_byte + NumDb'(1);
                  r_state <= READ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Outputs follow the state combinationally so the CPU stalls and the bus is released without delay.
   always_comb begin
      cpu_rdy    = 1'b1;
      dma_active = 1'b0;
      bus_addr   = cpu_addr;
      bus_wdata  = cpu_data;
      bus_r_bw   = cpu_r_bw;
      case (r_state)
         HALT, ALIGN: begin
            cpu_rdy    = 1'b0;
            dma_active = 1'b1;
            bus_addr   = {r_page, {NumDb{1'b0}}};
            bus_wdata  = r_hold;
            bus_r_bw   = 1'b1;
         end
         READ: begin
            cpu_rdy    = 1'b0;
            dma_active = 1'b1;
            bus_addr   = {r_page, r_byte};
            bus_wdata  = r_hold;
            bus_r_bw   = 1'b1;
         end
         WRITE: begin
            cpu_rdy    = 1'b0;
            dma_active = 1'b1;
            bus_addr   = OAM_PORT;
            bus_wdata  = r_hold;
            bus_r_bw   = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Scoreboard bench for nes_oam_dma: a memory model feeds bus reads, the expected
// OAM write stream and halt length are queued at trigger time and checked by a monitor.
module tb_nes_oam_dma;

   typedef struct {
      logic [15:0] rdAddr;
      logic [7:0]  data;
   } expWrite_t;

   logic        clk;
   logic        rst_b;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_r_bw;
   logic        cpu_rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_r_bw;
   logic [7:0]  bus_rdata;
   logic        dma_active;

   logic [7:0]  mem [0:65535];
   expWrite_t   expQ[$];
   int          haltQ[$];
   int          checks = 0;
   int          errors = 0;
   int          writesSeen = 0;
   int          haltCnt = 0;
   int          cyc = 0;
   logic [15:0] lastRd = 16'h0;

   nes_oam_dma #(
      .NumDb(8),
      .DMA_REG(16'h4014),
      .OAM_PORT(16'h2004)
   ) dut (
      .clk(clk),
      .rst_b(rst_b),
      .cpu_addr(cpu_addr),
      .cpu_data(cpu_data),
      .cpu_r_bw(cpu_r_bw),
      .cpu_rdy(cpu_rdy),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_r_bw(bus_r_bw),
      .bus_rdata(bus_rdata),
      .dma_active(dma_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // System memory answers reads in the same cycle.
   assign bus_rdata = mem[bus_addr];

   // Cycle parity as seen by the bench: edges since reset release, even count = even cycle.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: consumes the expected write stream and halt lengths as the DUT produces them.
   always @(negedge clk) begin
      if (!rst_b) begin
         haltCnt = 0;
      end else begin
         check("active_vs_rdy", dma_active, !cpu_rdy);
         if (!cpu_rdy) begin
            haltCnt++;
         end else if (haltCnt != 0) begin
            if (haltQ.size() == 0) check("unexpected_halt", haltCnt, 0);
            else                   check("halt_cycles", haltCnt, haltQ.pop_front());
            haltCnt = 0;
         end
         if (dma_active && bus_r_bw) lastRd = bus_addr;
         if (dma_active && !bus_r_bw) begin
            writesSeen++;
            check("write_addr", bus_addr, 16'h2004);
            if (expQ.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               expWrite_t e;
               e = expQ.pop_front();
               check("read_addr", lastRd, e.rdAddr);
               check("write_data", bus_wdata, e.data);
            end
         end
      end
   end

   task automatic driveIdle();
      cpu_addr = 16'h8000;
      cpu_data = 8'h00;
      cpu_r_bw = 1'b1;
   endtask

   // CPU activity while halted, including writes to the trigger register that must be ignored.
   task automatic driveGarbage();
      if (writesSeen < 240) begin
         cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
         cpu_data = 8'($urandom);
         cpu_r_bw = 1'($urandom);
      end else begin
         driveIdle();
      end
   endtask

   task automatic checkPassThrough(input string tag);
      check({tag, "_addr"}, bus_addr, cpu_addr);
      check({tag, "_wdata"}, bus_wdata, cpu_data);
      check({tag, "_rbw"}, bus_r_bw, cpu_r_bw);
      check({tag, "_rdy"}, cpu_rdy, 1'b1);
      check({tag, "_active"}, dma_active, 1'b0);
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic rbw);
      @(negedge clk);
      #1;
      cpu_addr = addr;
      cpu_data = data;
      cpu_r_bw = rbw;
      #1;
      checkPassThrough("passthru");
   endtask

   // Reference model: a trigger with page P yields 256 writes of mem[P00..PFF] in address order.
   task automatic triggerDma(input logic [7:0] page, input bit wantAlign);
      @(negedge clk);
      #1;
      driveIdle();
      if (cyc[0] != wantAlign) begin
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < 256; i++) begin
         expWrite_t e;
         e.rdAddr = {page, 8'(i)};
         e.data   = mem[{page, 8'(i)}];
         expQ.push_back(e);
      end
      haltQ.push_back(wantAlign ? 514 : 513);
      writesSeen = 0;
      cpu_addr = 16'h4014;
      cpu_data = page;
      cpu_r_bw = 1'b0;
      #1;
      checkPassThrough("trigger");
   endtask

   task automatic checkOutput(input string tag);
      bit done;
      done = 0;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         #1;
         if (cpu_rdy && expQ.size() == 0 && haltQ.size() == 0) begin
            done = 1;
            break;
         end
         driveGarbage();
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_writes"}, writesSeen, 256);
      driveIdle();
      cpu_addr = 16'h0123;
      #1;
      checkPassThrough({tag, "_after"});
   endtask

   initial begin
      rst_b = 1'b0;
      driveIdle();
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
      repeat (2) @(negedge clk);
      #1;
      checkPassThrough("reset");
      rst_b = 1'b1;

      applyStimulus(16'h8000, 8'h00, 1'b1);
      applyStimulus(16'h0300, 8'h55, 1'b0);
      for (int n = 0; n < 8; n++) begin
         logic [15:0] ra;
         ra = 16'($urandom);
         if (ra == 16'h4014) ra = 16'h4015;
         applyStimulus(ra, 8'($urandom), 1'($urandom));
      end

      triggerDma(8'h02, 1'b0);
      checkOutput("even");
      triggerDma(8'h02, 1'b1);
      checkOutput("odd");

      applyStimulus(16'h4014, 8'h07, 1'b1);
      applyStimulus(16'h4015, 8'h07, 1'b0);
      for (int n = 0; n < 4; n++) applyStimulus(16'h8000, 8'h00, 1'b1);

      triggerDma(8'($urandom_range(0, 254)), 1'($urandom));
      checkOutput("random");
      triggerDma(8'hFF, 1'($urandom));
      checkOutput("pageff");

      triggerDma(8'h03, 1'($urandom));
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (writesSeen >= 100) break;
         driveGarbage();
      end
      check("reset_reached_100", writesSeen >= 100, 1'b1);
      rst_b = 1'b0;
      #1;
      checkPassThrough("midreset");
      expQ.delete();
      haltQ.delete();
      @(negedge clk);
      #1;
      driveIdle();
      @(negedge clk);
      #1;
      rst_b = 1'b1;

      triggerDma(8'h03, 1'($urandom));
      checkOutput("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
